// File: rtl/rv_pipe_pkg.sv
// Shared encodings for the RV32I pipeline stages: ALU operations and forwarding selects.
package rv_pipe_pkg;
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;
endpackage

// File: rtl/alu.sv
// 32-bit ALU: add, sub, and, or, slt, with zero/negative/overflow/carry flags.
module alu
   import rv_pipe_pkg::*;
(
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic [2:0]  ALUControl,
   output logic [31:0] Result,
   output logic        Z,
   output logic        N,
   output logic        V,
   output logic        C
);
   logic        sub;
   logic        arith;
   logic [31:0] bx;
   logic [32:0] sum;

   assign sub   = (ALUControl == ALU_SUB) || (ALUControl == ALU_SLT);
   assign arith = (ALUControl == ALU_ADD) || sub;
   assign bx    = sub ? ~B : B;
   assign sum   = {1'b0, A} + {1'b0, bx} + {32'd0, sub};

   always_comb begin
      Result = 32'd0;
      case (ALUControl)
         ALU_ADD, ALU_SUB: Result = sum[31:0];
         ALU_AND:          Result = A & B;
         ALU_OR:           Result = A | B;
         // slt follows the raw sign of A-B; overflow is deliberately not folded in
         ALU_SLT:          Result = {31'd0, sum[31]};
         default:          Result = 32'd0;
      endcase
   end

   assign Z = (Result == 32'd0);
   assign N = Result[31];
   assign C = arith & sum[32];
   assign V = arith & (A[31] == bx[31]) & (sum[31] != A[31]);
endmodule

// File: rtl/execute_cycle.sv
// EX stage: operand forwarding, ALU-B source select, beq resolution and the EX/MEM register.
module execute_cycle
   import rv_pipe_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int REGW = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            RegWriteE,
   input  logic            MemWriteE,
   input  logic            ResultSrcE,
   input  logic            BranchE,
   input  logic            ALUSrcE,
   input  logic [2:0]      ALUControlE,
   input  logic [XLEN-1:0] RD1E,
   input  logic [XLEN-1:0] RD2E,
   input  logic [XLEN-1:0] ImmExtE,
   input  logic [REGW-1:0] RdE,
   input  logic [XLEN-1:0] PCE,
   input  logic [XLEN-1:0] PCPlus4E,
   input  logic [1:0]      ForwardAE,
   input  logic [1:0]      ForwardBE,
   input  logic [XLEN-1:0] ResultW,
   input  logic            StallM,
   input  logic            FlushM,
   output logic            PCSrcE,
   output logic [XLEN-1:0] PCTargetE,
   output logic            RegWriteM,
   output logic            MemWriteM,
   output logic            ResultSrcM,
   output logic [REGW-1:0] RdM,
   output logic [XLEN-1:0] ALUResultM,
   output logic [XLEN-1:0] WriteDataM,
   output logic [XLEN-1:0] PCPlus4M
);
   logic [XLEN-1:0] srca, srcb_fwd, srcb, alu_result;
   logic            zero;
   logic            alu_n_unused, alu_v_unused, alu_c_unused;

   // MEM-stage forward taps the registered ALUResultM, so no combinational loop through the ALU
   always_comb begin
      srca = RD1E;
      case (ForwardAE)
         FWD_WB:  srca = ResultW;
         FWD_MEM: srca = ALUResultM;
         default: srca = RD1E;
      endcase
   end

   always_comb begin
      srcb_fwd = RD2E;
      case (ForwardBE)
         FWD_WB:  srcb_fwd = ResultW;
         FWD_MEM: srcb_fwd = ALUResultM;
         default: srcb_fwd = RD2E;
      endcase
   end

   assign srcb = ALUSrcE ? ImmExtE : srcb_fwd;

   alu u_alu (
      .A          (srca),
      .B          (srcb),
      .ALUControl (ALUControlE),
      .Result     (alu_result),
      .Z          (zero),
      .N          (alu_n_unused),
      .V          (alu_v_unused),
      .C          (alu_c_unused)
   );

   // Stall/flush interaction with the redirect belongs to the hazard unit
   assign PCSrcE    = BranchE & zero;
   assign PCTargetE = PCE + ImmExtE;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         RegWriteM  <= 1'b0;
         MemWriteM  <= 1'b0;
         ResultSrcM <= 1'b0;
         RdM        <= '0;
         ALUResultM <= '0;
         WriteDataM <= '0;
         PCPlus4M   <= '0;
      end else if (FlushM) begin
         RegWriteM  <= 1'b0;
         MemWriteM  <= 1'b0;
         ResultSrcM <= 1'b0;
         RdM        <= '0;
         ALUResultM <= '0;
         WriteDataM <= '0;
         PCPlus4M   <= '0;
      end else if (!StallM) begin
         RegWriteM  <= RegWriteE;
         MemWriteM  <= MemWriteE;
         ResultSrcM <= ResultSrcE;
         RdM        <= RdE;
         ALUResultM <= alu_result;
         WriteDataM <= srcb_fwd;
         PCPlus4M   <= PCPlus4E;
      end
   end
endmodule

// File: tb/tb_execute_cycle.sv
// Directed bench for execute_cycle: reset, ALU ops, forwarding, branch, stall/flush.
module tb_execute_cycle;
   logic        clk, rst;
   logic        RegWriteE, MemWriteE, ResultSrcE, BranchE, ALUSrcE;
   logic [2:0]  ALUControlE;
   logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E, ResultW;
   logic [4:0]  RdE;
   logic [1:0]  ForwardAE, ForwardBE;
   logic        StallM, FlushM;
   logic        PCSrcE;
   logic [31:0] PCTargetE;
   logic        RegWriteM, MemWriteM, ResultSrcM;
   logic [4:0]  RdM;
   logic [31:0] ALUResultM, WriteDataM, PCPlus4M;

   int errors = 0;
   int checks = 0;

   execute_cycle dut (
      .clk(clk), .rst(rst),
      .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
      .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
      .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .RdE(RdE),
      .PCE(PCE), .PCPlus4E(PCPlus4E), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .ResultW(ResultW), .StallM(StallM), .FlushM(FlushM),
      .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
      .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
      .RdM(RdM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle_inputs();
      RegWriteE = 0; MemWriteE = 0; ResultSrcE = 0; BranchE = 0; ALUSrcE = 0;
      ALUControlE = 3'b000; RD1E = 0; RD2E = 0; ImmExtE = 0; RdE = 0;
      PCE = 0; PCPlus4E = 0; ForwardAE = 2'b00; ForwardBE = 2'b00; ResultW = 0;
      StallM = 0; FlushM = 0;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 0; idle_inputs();
      tick(); tick();
      checks++;
      if ({RegWriteM, MemWriteM, ResultSrcM, RdM, ALUResultM, WriteDataM, PCPlus4M} !== '0) begin
         errors++; $display("FAIL reset_initial: got RegWriteM=%b ALUResultM=%h, expected all zero", RegWriteM, ALUResultM);
      end
      rst = 1;
      RD1E = 1; RD2E = 2; RdE = 4; RegWriteE = 1; MemWriteE = 1; ResultSrcE = 1; PCPlus4E = 32'h44;
      tick();
      checks++;
      if (ALUResultM !== 32'd3 || RdM !== 5'd4 || PCPlus4M !== 32'h44 || MemWriteM !== 1'b1) begin
         errors++; $display("FAIL reset_preload: got alu=%h rd=%0d pc4=%h mw=%b, expected 3 4 44 1", ALUResultM, RdM, PCPlus4M, MemWriteM);
      end
      #2 rst = 0;
      BranchE = 1; RD1E = 9; RD2E = 9; ALUControlE = 3'b001;
      #1;
      checks++;
      if ({RegWriteM, MemWriteM, ResultSrcM, RdM, ALUResultM, WriteDataM, PCPlus4M} !== '0) begin
         errors++; $display("FAIL reset_async: got RegWriteM=%b ALUResultM=%h PCPlus4M=%h, expected zero before edge", RegWriteM, ALUResultM, PCPlus4M);
      end
      checks++;
      if (PCSrcE !== 1'b1) begin
         errors++; $display("FAIL reset_pcsrc: got %b expected 1", PCSrcE);
      end
      tick();
      checks++;
      if (RegWriteM !== 1'b0 || ALUResultM !== 32'd0 || RdM !== 5'd0) begin
         errors++; $display("FAIL reset_hold_on_edge: got rw=%b alu=%h rd=%0d, expected 0", RegWriteM, ALUResultM, RdM);
      end
      rst = 1; idle_inputs();
      tick();
   endtask

   task automatic test_add();
      idle_inputs();
      RD1E = 5; RD2E = 7; RdE = 3; RegWriteE = 1; PCPlus4E = 32'h208;
      tick();
      checks++;
      if (ALUResultM !== 32'd12 || WriteDataM !== 32'd7 || RdM !== 5'd3 || RegWriteM !== 1'b1 || PCPlus4M !== 32'h208) begin
         errors++; $display("FAIL add: got alu=%0d wd=%0d rd=%0d rw=%b pc4=%h, expected 12 7 3 1 208", ALUResultM, WriteDataM, RdM, RegWriteM, PCPlus4M);
      end
      RD1E = 32'hFFFFFFFF; RD2E = 32'd2;
      tick();
      checks++;
      if (ALUResultM !== 32'd1) begin
         errors++; $display("FAIL add_wrap: got %h expected 00000001", ALUResultM);
      end
   endtask

   task automatic test_logic();
      idle_inputs();
      RD1E = 32'hF0F0_00FF; RD2E = 32'h0FF0_0F0F; ALUControlE = 3'b010;
      tick();
      checks++;
      if (ALUResultM !== 32'h00F0_000F) begin
         errors++; $display("FAIL and: got %h expected 00f0000f", ALUResultM);
      end
      ALUControlE = 3'b011; ForwardAE = 2'b11;
      tick();
      checks++;
      if (ALUResultM !== 32'hFFF0_0FFF) begin
         errors++; $display("FAIL or_fwd11: got %h expected fff00fff", ALUResultM);
      end
   endtask

   task automatic test_forwarding();
      idle_inputs();
      RD1E = 32'h8; RD2E = 32'h8;
      tick();
      ForwardAE = 2'b10; ForwardBE = 2'b01; ResultW = 32'h20; ALUControlE = 3'b001;
      RD1E = 32'h1234; RD2E = 32'h5678;
      tick();
      checks++;
      if (ALUResultM !== 32'hFFFF_FFF0 || WriteDataM !== 32'h20) begin
         errors++; $display("FAIL forward_sub: got alu=%h wd=%h expected fffffff0 00000020", ALUResultM, WriteDataM);
      end
      ForwardAE = 2'b10; ForwardBE = 2'b10; ALUControlE = 3'b000;
      tick();
      checks++;
      if (ALUResultM !== 32'hFFFF_FFE0 || WriteDataM !== 32'hFFFF_FFF0) begin
         errors++; $display("FAIL forward_both_mem: got alu=%h wd=%h expected ffffffe0 fffffff0", ALUResultM, WriteDataM);
      end
   endtask

   task automatic test_branch();
      idle_inputs();
      BranchE = 1; RD1E = 9; RD2E = 9; ALUControlE = 3'b001; PCE = 32'h100; ImmExtE = 32'hFFFF_FFF8;
      #1;
      checks++;
      if (PCSrcE !== 1'b1 || PCTargetE !== 32'hF8) begin
         errors++; $display("FAIL branch_taken: got pcsrc=%b target=%h expected 1 000000f8", PCSrcE, PCTargetE);
      end
      RD2E = 8;
      #1;
      checks++;
      if (PCSrcE !== 1'b0) begin
         errors++; $display("FAIL branch_not_taken: got %b expected 0", PCSrcE);
      end
      RD2E = 9; BranchE = 0;
      #1;
      checks++;
      if (PCSrcE !== 1'b0) begin
         errors++; $display("FAIL branch_disabled: got %b expected 0", PCSrcE);
      end
      tick();
   endtask

   task automatic test_stall_flush();
      idle_inputs();
      RD1E = 10; RD2E = 20; RdE = 7; RegWriteE = 1; MemWriteE = 1; PCPlus4E = 32'h400;
      tick();
      StallM = 1; RD1E = 1; RD2E = 1; RdE = 2; RegWriteE = 0; MemWriteE = 0; PCPlus4E = 32'h500;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (ALUResultM !== 32'd30 || WriteDataM !== 32'd20 || RdM !== 5'd7 || RegWriteM !== 1'b1 ||
             MemWriteM !== 1'b1 || PCPlus4M !== 32'h400) begin
            errors++; $display("FAIL stall_hold%0d: got alu=%0d wd=%0d rd=%0d rw=%b mw=%b pc4=%h expected 30 20 7 1 1 400",
                               i, ALUResultM, WriteDataM, RdM, RegWriteM, MemWriteM, PCPlus4M);
         end
         RD1E = RD1E + 3;
      end
      FlushM = 1;
      tick();
      checks++;
      if ({RegWriteM, MemWriteM, ResultSrcM, RdM, ALUResultM, WriteDataM, PCPlus4M} !== '0) begin
         errors++; $display("FAIL flush_over_stall: got rw=%b mw=%b alu=%h pc4=%h expected all zero", RegWriteM, MemWriteM, ALUResultM, PCPlus4M);
      end
      StallM = 0; FlushM = 0; RD1E = 4; RD2E = 6;
      tick();
      checks++;
      if (ALUResultM !== 32'd10 || PCPlus4M !== 32'h500) begin
         errors++; $display("FAIL resume: got alu=%0d pc4=%h expected 10 500", ALUResultM, PCPlus4M);
      end
   endtask

   task automatic test_slt_imm();
      idle_inputs();
      RD1E = 32'hFFFF_FFFF; RD2E = 32'h55; ImmExtE = 1; ALUSrcE = 1; ALUControlE = 3'b101;
      tick();
      checks++;
      if (ALUResultM !== 32'd1 || WriteDataM !== 32'h55) begin
         errors++; $display("FAIL slt_imm: got alu=%h wd=%h expected 00000001 00000055", ALUResultM, WriteDataM);
      end
      RD1E = 5; ImmExtE = 3;
      tick();
      checks++;
      if (ALUResultM !== 32'd0) begin
         errors++; $display("FAIL slt_false: got %h expected 00000000", ALUResultM);
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_logic();
      test_forwarding();
      test_branch();
      test_stall_flush();
      test_slt_imm();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
